// File: rtl/present_sbox_layer_seq.sv
// Sequential PRESENT S-box layer: substitutes LANES nibbles of the state per cycle,
// forward or inverse, with valid/ready handshakes on input and output.
module present_sbox_layer_seq #(
  parameter int STATE_W = 64,
  parameter int LANES   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_data,
  input  logic               in_inv,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data,
  output logic               busy
);

  localparam int NCHUNK  = STATE_W / (4 * LANES);
  localparam int CNT_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int CHUNK_W = 4 * LANES;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic [3:0] fwd_sbox(input logic [3:0] x);
    case (x)
      4'h0: fwd_sbox = 4'hC;  4'h1: fwd_sbox = 4'h5;
      4'h2: fwd_sbox = 4'h6;  4'h3: fwd_sbox = 4'hB;
      4'h4: fwd_sbox = 4'h9;  4'h5: fwd_sbox = 4'h0;
      4'h6: fwd_sbox = 4'hA;  4'h7: fwd_sbox = 4'hD;
      4'h8: fwd_sbox = 4'h3;  4'h9: fwd_sbox = 4'hE;
      4'hA: fwd_sbox = 4'hF;  4'hB: fwd_sbox = 4'h8;
      4'hC: fwd_sbox = 4'h4;  4'hD: fwd_sbox = 4'h7;
      4'hE: fwd_sbox = 4'h1;  default: fwd_sbox = 4'h2;
    endcase
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    case (x)
      4'h0: inv_sbox = 4'h5;  4'h1: inv_sbox = 4'hE;
      4'h2: inv_sbox = 4'hF;  4'h3: inv_sbox = 4'h8;
      4'h4: inv_sbox = 4'hC;  4'h5: inv_sbox = 4'h1;
      4'h6: inv_sbox = 4'h2;  4'h7: inv_sbox = 4'hD;
      4'h8: inv_sbox = 4'hB;  4'h9: inv_sbox = 4'h4;
      4'hA: inv_sbox = 4'h6;  4'hB: inv_sbox = 4'h3;
      4'hC: inv_sbox = 4'h0;  4'hD: inv_sbox = 4'h7;
      4'hE: inv_sbox = 4'h9;  default: inv_sbox = 4'hA;
    endcase
  endfunction

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 mode_q;
  logic [STATE_W-1:0]   work_q;
  logic [STATE_W-1:0]   work_d;
  logic [CHUNK_W-1:0]   chunk_in;
  logic [CHUNK_W-1:0]   chunk_out;

  // The chunk currently being substituted; chunk 0 holds the least significant nibbles.
  assign chunk_in = work_q[int'(cnt_q) * CHUNK_W +: CHUNK_W];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign chunk_out[gi*4 +: 4] = mode_q ? inv_sbox(chunk_in[gi*4 +: 4])
                                         : fwd_sbox(chunk_in[gi*4 +: 4]);
  end

  always_comb begin
    work_d = work_q;
    work_d[int'(cnt_q) * CHUNK_W +: CHUNK_W] = chunk_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      work_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            work_q  <= in_data;
            mode_q  <= in_inv;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          work_q <= work_d;
          if (cnt_q == CNT_W'(NCHUNK - 1)) begin
            cnt_q   <= '0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          // No new block is accepted here even if in_valid is high.
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign out_data  = work_q;

endmodule

// File: tb/tb_present_sbox_layer_seq.sv
// Directed bench for present_sbox_layer_seq: default 4-lane instance plus a 16-lane instance.
module tb_present_sbox_layer_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // 4-lane instance
  logic        a_rst, a_in_valid, a_in_ready, a_in_inv, a_out_valid, a_out_ready, a_busy;
  logic [63:0] a_in_data, a_out_data;
  // 16-lane instance
  logic        b_rst, b_in_valid, b_in_ready, b_in_inv, b_out_valid, b_out_ready, b_busy;
  logic [63:0] b_in_data, b_out_data;

  present_sbox_layer_seq #(.STATE_W(64), .LANES(4)) dut (
    .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_inv(a_in_inv), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .busy(a_busy)
  );

  present_sbox_layer_seq #(.STATE_W(64), .LANES(16)) dut16 (
    .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_inv(b_in_inv), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .busy(b_busy)
  );

  // Accept one block on instance A and wait for out_valid; lat = -1 on timeout.
  task automatic start_a(input logic [63:0] din, input logic inv, output int lat);
    lat = -1;
    for (int i = 0; i < 20 && !a_in_ready; i++) begin
      @(posedge clk); #1;
    end
    a_in_data = din; a_in_inv = inv; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_in_data = 64'hDEAD_BEEF_DEAD_BEEF; a_in_inv = ~inv;
    for (int i = 1; i <= 20; i++) begin
      if (a_out_valid) begin lat = i - 1; break; end
      @(posedge clk); #1;
    end
    if (a_out_valid && lat < 0) lat = 20;
  endtask

  task automatic start_b(input logic [63:0] din, input logic inv, output int lat);
    lat = -1;
    for (int i = 0; i < 20 && !b_in_ready; i++) begin
      @(posedge clk); #1;
    end
    b_in_data = din; b_in_inv = inv; b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (b_out_valid) begin lat = i - 1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    a_rst = 1'b1; b_rst = 1'b1;
    a_in_valid = 0; a_in_data = '0; a_in_inv = 0; a_out_ready = 1;
    b_in_valid = 0; b_in_data = '0; b_in_inv = 0; b_out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({a_in_ready, a_out_valid, a_busy} !== 3'b100 || a_out_data !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_a: rdy/vld/busy=%b data=%h, required 100 data=0",
               {a_in_ready, a_out_valid, a_busy}, a_out_data);
    end
    n_tests++;
    if ({b_in_ready, b_out_valid, b_busy} !== 3'b100 || b_out_data !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_b: rdy/vld/busy=%b data=%h, required 100 data=0",
               {b_in_ready, b_out_valid, b_busy}, b_out_data);
    end
    a_rst = 1'b0; b_rst = 1'b0;
    @(posedge clk); #1;
    $display("[TB] reset checked");
  endtask

  // T1 with chunk-order check after the first RUN cycle and input change after accept.
  task automatic test_fwd;
    int lat;
    a_in_data = 64'h0123456789ABCDEF; a_in_inv = 1'b0; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_in_data = 64'hFFFF_FFFF_FFFF_FFFF; a_in_inv = 1'b1;
    n_tests++;
    if (a_busy !== 1'b1 || a_in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fwd_busy: busy=%b in_ready=%b, required busy=1 in_ready=0", a_busy, a_in_ready);
    end
    @(posedge clk); #1;
    n_tests++;
    if (a_out_data !== 64'h0123456789AB4712) begin
      n_fail++;
      $display("FAIL fwd_chunk0: got %h, required 0123456789ab4712", a_out_data);
    end
    lat = 1;
    for (int i = 0; i < 20 && !a_out_valid; i++) begin
      @(posedge clk); #1; lat++;
    end
    n_tests++;
    if (lat !== 4 || a_out_data !== 64'hC56B90AD3EF84712) begin
      n_fail++;
      $display("FAIL fwd_T1: lat=%0d data=%h, required lat=4 data=c56b90ad3ef84712", lat, a_out_data);
    end
    @(posedge clk); #1;
    $display("[TB] fwd T1 -> %h latency %0d", a_out_data, lat);
  endtask

  task automatic test_inv;
    int lat;
    start_a(64'hC56B90AD3EF84712, 1'b1, lat);
    n_tests++;
    if (lat !== 4 || a_out_data !== 64'h0123456789ABCDEF) begin
      n_fail++;
      $display("FAIL inv_T2: lat=%0d data=%h, required lat=4 data=0123456789abcdef", lat, a_out_data);
    end
    $display("[TB] inv T2 -> %h", a_out_data);
    @(posedge clk); #1;
  endtask

  task automatic test_const;
    int lat;
    start_a(64'h0, 1'b0, lat);
    n_tests++;
    if (lat !== 4 || a_out_data !== 64'hCCCCCCCCCCCCCCCC) begin
      n_fail++;
      $display("FAIL zeros_fwd: lat=%0d data=%h, required lat=4 data=cccccccccccccccc", lat, a_out_data);
    end
    $display("[TB] zeros fwd -> %h", a_out_data);
    @(posedge clk); #1;
    start_a(64'hFFFFFFFFFFFFFFFF, 1'b1, lat);
    n_tests++;
    if (lat !== 4 || a_out_data !== 64'hAAAAAAAAAAAAAAAA) begin
      n_fail++;
      $display("FAIL ones_inv: lat=%0d data=%h, required lat=4 data=aaaaaaaaaaaaaaaa", lat, a_out_data);
    end
    $display("[TB] all-F inv -> %h", a_out_data);
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    int lat;
    int bad;
    a_out_ready = 1'b0;
    start_a(64'h0123456789ABCDEF, 1'b0, lat);
    n_tests++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL bp_latency: got %0d, required 4", lat);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      a_in_valid = 1'b1; a_in_data = 64'h1111_2222_3333_4444;
      @(posedge clk); #1;
      n_tests++;
      if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || a_out_data !== 64'hC56B90AD3EF84712) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: vld=%b rdy=%b data=%h, required 1 0 c56b90ad3ef84712",
                 i, a_out_valid, a_in_ready, a_out_data);
      end
    end
    // out_ready and in_valid both high in DONE: block must not be re-accepted.
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    n_tests++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: vld=%b rdy=%b busy=%b, required 0 1 0", a_out_valid, a_in_ready, a_busy);
    end
    $display("[TB] backpressure 10 cycles then release");
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run;
    int lat;
    a_in_data = 64'h0123456789ABCDEF; a_in_inv = 1'b0; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    @(posedge clk); #1;
    a_rst = 1'b1;
    @(posedge clk); #1;
    a_rst = 1'b0;
    n_tests++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_out_data !== 64'h0 || a_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: rdy=%b vld=%b busy=%b data=%h, required 1 0 0 0",
               a_in_ready, a_out_valid, a_busy, a_out_data);
    end
    start_a(64'h0123456789ABCDEF, 1'b0, lat);
    n_tests++;
    if (lat !== 4 || a_out_data !== 64'hC56B90AD3EF84712) begin
      n_fail++;
      $display("FAIL rst_rerun: lat=%0d data=%h, required lat=4 data=c56b90ad3ef84712", lat, a_out_data);
    end
    $display("[TB] reset mid-run, rerun -> %h", a_out_data);
    @(posedge clk); #1;
  endtask

  task automatic test_lanes16;
    int lat;
    logic [63:0] pt, ct;
    int rt_fail;
    start_b(64'h0123456789ABCDEF, 1'b0, lat);
    n_tests++;
    if (lat !== 1 || b_out_data !== 64'hC56B90AD3EF84712) begin
      n_fail++;
      $display("FAIL l16_T1: lat=%0d data=%h, required lat=1 data=c56b90ad3ef84712", lat, b_out_data);
    end
    $display("[TB] lanes16 T1 -> %h latency %0d", b_out_data, lat);
    @(posedge clk); #1;
    rt_fail = 0;
    for (int k = 0; k < 1000; k++) begin
      pt = {$urandom, $urandom};
      start_b(pt, 1'b0, lat);
      ct = b_out_data;
      @(posedge clk); #1;
      start_b(ct, 1'b1, lat);
      n_tests++;
      if (lat !== 1 || b_out_data !== pt) begin
        n_fail++; rt_fail++;
        if (rt_fail < 10)
          $display("FAIL l16_roundtrip[%0d]: lat=%0d data=%h, required lat=1 data=%h", k, lat, b_out_data, pt);
      end
      @(posedge clk); #1;
    end
    $display("[TB] lanes16 round-trip 1000 blocks, %0d bad", rt_fail);
  endtask

  initial begin
    test_reset;
    test_fwd;
    test_inv;
    test_const;
    test_backpressure;
    test_reset_mid_run;
    test_lanes16;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
